// File: rtl/filt_pkg.sv
// Shared definitions for the FIR ring-reader: bank selects, default widths,
// FSM encoding and the ring address helper.
package filt_pkg;

  // Coefficient bank selects (upper two bits of coef_addr)
  localparam logic [1:0] FILT_SEL_LPF = 2'b00;
  localparam logic [1:0] FILT_SEL_HPF = 2'b01;
  localparam logic [1:0] FILT_SEL_BPF = 2'b10;

  // Default geometry
  localparam int unsigned FILT_M         = 211;
  localparam int unsigned FILT_ADDR_SIZE = 8;
  localparam int unsigned FILT_DATA_SIZE = 16;
  localparam int unsigned FILT_COEF_SIZE = 32;
  localparam int unsigned FILT_COEF_FRAC = 30;
  localparam int unsigned FILT_ACC_SIZE  = 57;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StOut
  } fir_state_e;

endpackage

// File: rtl/fir_mac_pipe.sv
// Three-stage multiply-accumulate pipe with final rescale and saturation.
// Stage 1: BRAM q valid; stage 2: registered product; stage 3: accumulator.
module fir_mac_pipe #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned COEF_SIZE = 32,
  parameter int unsigned COEF_FRAC = 30,
  parameter int unsigned ACC_SIZE  = 57
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 tap_vld,
  input  logic                 dc_remove,
  input  logic [DATA_SIZE-1:0] xant_q,
  input  logic [COEF_SIZE-1:0] coef_q,
  output logic [DATA_SIZE-1:0] y_sat
);

  localparam int unsigned PROD_W = DATA_SIZE + 1 + COEF_SIZE;

  // Mid-scale offset in the sample and accumulator domains
  localparam logic signed [DATA_SIZE:0] SampleMid = {2'b01, {(DATA_SIZE - 1){1'b0}}};
  localparam logic signed [ACC_SIZE-1:0] AccMid =
      {{(ACC_SIZE - DATA_SIZE){1'b0}}, 1'b1, {(DATA_SIZE - 1){1'b0}}};
  localparam logic signed [ACC_SIZE-1:0] AccFull =
      {{(ACC_SIZE - DATA_SIZE){1'b0}}, {DATA_SIZE{1'b1}}};

  logic                       v1_q;
  logic                       v2_q;
  logic signed [PROD_W-1:0]   p_q;
  logic signed [ACC_SIZE-1:0] acc_q;

  logic signed [DATA_SIZE:0]    s_val;
  logic signed [COEF_SIZE-1:0]  c_val;
  logic signed [PROD_W-1:0]     p_d;
  logic signed [ACC_SIZE-1:0]   y_shift;
  logic signed [ACC_SIZE-1:0]   y_off;

  // Signed sample conversion and product for the tap currently on the BRAM outputs
  always_comb begin
    s_val = $signed({1'b0, xant_q});
    if (dc_remove) begin
      s_val = s_val - SampleMid;
    end
    c_val = $signed(coef_q);
    p_d   = s_val * c_val;
  end

  // Valid bits, product register and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      p_q   <= '0;
      acc_q <= '0;
    end else if (clear) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      v1_q <= tap_vld;
      v2_q <= v1_q;
      p_q  <= p_d;
      if (v2_q) begin
        acc_q <= acc_q + {{(ACC_SIZE - PROD_W){p_q[PROD_W-1]}}, p_q};
      end
    end
  end

  // Rescale (floor shift), restore offset, clamp to the unsigned output range
  always_comb begin
    y_shift = acc_q >>> COEF_FRAC;
    y_off   = dc_remove ? (y_shift + AccMid) : y_shift;
    if (y_off[ACC_SIZE-1]) begin
      y_sat = '0;
    end else if (y_off > AccFull) begin
      y_sat = {DATA_SIZE{1'b1}};
    end else begin
      y_sat = y_off[DATA_SIZE-1:0];
    end
  end

endmodule

// File: rtl/fir_ring_reader.sv
// FIR engine reading the sample ring newest-first; drives the xant and
// coefficient BRAMs, accumulates M taps and reports one filtered sample.
module fir_ring_reader
  import filt_pkg::*;
#(
  parameter int unsigned M         = FILT_M,
  parameter int unsigned ADDR_SIZE = FILT_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = FILT_DATA_SIZE,
  parameter int unsigned COEF_SIZE = FILT_COEF_SIZE,
  parameter int unsigned COEF_FRAC = FILT_COEF_FRAC,
  parameter int unsigned ACC_SIZE  = FILT_ACC_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_SIZE-1:0]   head_addr,
  input  logic [1:0]             coef_sel,
  input  logic                   dc_remove,
  output logic [ADDR_SIZE-1:0]   xant_addr,
  output logic                   xant_ce,
  input  logic [DATA_SIZE-1:0]   xant_q,
  output logic [ADDR_SIZE+1:0]   coef_addr,
  output logic                   coef_ce,
  input  logic [COEF_SIZE-1:0]   coef_q,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_SIZE-1:0]   result
);

  localparam logic [ADDR_SIZE-1:0] MAddr    = ADDR_SIZE'(M);
  localparam logic [ADDR_SIZE-1:0] LastTap  = ADDR_SIZE'(M - 1);
  localparam logic [1:0]           DrainEnd = 2'd2;

  fir_state_e             state_q;
  logic [ADDR_SIZE-1:0]   k_q;
  logic [ADDR_SIZE-1:0]   head_l;
  logic [1:0]             sel_l;
  logic                   dc_l;
  logic [1:0]             drain_q;

  logic                   start_acc;
  logic [ADDR_SIZE-1:0]   head_in;
  logic [ADDR_SIZE-1:0]   k_nxt;
  logic [ADDR_SIZE-1:0]   addr_nxt;
  logic [DATA_SIZE-1:0]   y_sat;

  // Start acceptance, head sanitising and next ring address (wraps modulo M)
  always_comb begin
    start_acc = (state_q == StIdle) && start;
    head_in   = (head_addr >= MAddr) ? '0 : head_addr;
    k_nxt     = k_q + ADDR_SIZE'(1);
    // Modular arithmetic in ADDR_SIZE bits gives the right answer as long as
    // the true address fits, which it always does.
    addr_nxt  = (head_l >= k_nxt) ? (head_l - k_nxt) : (head_l - k_nxt + MAddr);
  end

  // Control FSM with registered BRAM controls, busy, done and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      head_l    <= '0;
      sel_l     <= '0;
      dc_l      <= 1'b0;
      drain_q   <= '0;
      xant_addr <= '0;
      xant_ce   <= 1'b0;
      coef_addr <= '0;
      coef_ce   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            head_l    <= head_in;
            sel_l     <= coef_sel;
            dc_l      <= dc_remove;
            k_q       <= '0;
            xant_addr <= head_in;
            coef_addr <= {coef_sel, {ADDR_SIZE{1'b0}}};
            xant_ce   <= 1'b1;
            coef_ce   <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (k_q == LastTap) begin
            xant_ce <= 1'b0;
            coef_ce <= 1'b0;
            drain_q <= '0;
            state_q <= StDrain;
          end else begin
            k_q       <= k_nxt;
            xant_addr <= addr_nxt;
            coef_addr <= {sel_l, k_nxt};
          end
        end
        StDrain: begin
          // Last product lands in the accumulator during the final drain cycle
          if (drain_q == DrainEnd) begin
            result  <= y_sat;
            done    <= 1'b1;
            state_q <= StOut;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        StOut: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  fir_mac_pipe #(
    .DATA_SIZE (DATA_SIZE),
    .COEF_SIZE (COEF_SIZE),
    .COEF_FRAC (COEF_FRAC),
    .ACC_SIZE  (ACC_SIZE)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .tap_vld   (xant_ce),
    .dc_remove (dc_l),
    .xant_q    (xant_q),
    .coef_q    (coef_q),
    .y_sat     (y_sat)
  );

endmodule

// File: tb/tb_fir_ring_reader.sv
// Bench for fir_ring_reader: behavioural BRAMs, table of evaluation vectors,
// expected results queued at start and compared at done.
module tb_fir_ring_reader;

  localparam int M = 211;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  head_addr;
  logic [1:0]  coef_sel;
  logic        dc_remove;
  logic [7:0]  xant_addr;
  logic        xant_ce;
  logic [15:0] xant_q;
  logic [9:0]  coef_addr;
  logic        coef_ce;
  logic [31:0] coef_q;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  logic [15:0] xmem [0:255];
  logic [31:0] cmem [0:1023];
  int          exp_q [$];

  typedef struct {
    string       name;
    int          xrand;
    int          xfill;
    int          xa;
    int          xv;
    int          crand;
    logic [31:0] cfill;
    int          ck;
    logic [31:0] cv;
    int          head;
    int          sel;
    int          dc;
    int          exp;
    int          extra;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  fir_ring_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .head_addr (head_addr),
    .coef_sel  (coef_sel),
    .dc_remove (dc_remove),
    .xant_addr (xant_addr),
    .xant_ce   (xant_ce),
    .xant_q    (xant_q),
    .coef_addr (coef_addr),
    .coef_ce   (coef_ce),
    .coef_q    (coef_q),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Synchronous-read BRAM models
  always @(posedge clk) begin
    if (xant_ce) xant_q <= xmem[xant_addr];
    if (coef_ce) coef_q <= cmem[coef_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int ring(input int head, input int k);
    int h;
    int a;
    h = (head >= M) ? 0 : head;
    a = h - k;
    if (a < 0) a += M;
    return a;
  endfunction

  // Reference filter: plain signed arithmetic over the current memories
  function automatic int model(input int head, input int sel, input int dc);
    longint acc;
    longint s;
    longint c;
    longint y;
    acc = 0;
    for (int k = 0; k < M; k++) begin
      s = longint'(xmem[ring(head, k)]);
      if (dc != 0) s = s - 32768;
      c = longint'($signed(cmem[sel * 256 + k]));
      acc += s * c;
    end
    y = acc >>> 30;
    if (dc != 0) y += 32768;
    if (y < 0) y = 0;
    if (y > 65535) y = 65535;
    return int'(y);
  endfunction

  task automatic setup(input vec_t v);
    for (int i = 0; i < 256; i++) xmem[i] = (v.xrand != 0) ? 16'($urandom) : 16'(v.xfill);
    if (v.xa >= 0) xmem[v.xa] = 16'(v.xv);
    for (int i = 0; i < 1024; i++) cmem[i] = $urandom;
    for (int k = 0; k < M; k++) begin
      if (v.crand != 0) cmem[v.sel * 256 + k] = 32'(int'($urandom_range(0, 1 << 29)) - (1 << 28));
      else cmem[v.sel * 256 + k] = v.cfill;
    end
    if (v.ck >= 0) cmem[v.sel * 256 + v.ck] = v.cv;
  endtask

  // One evaluation; entered and left at #1 after a rising edge with the DUT idle
  task automatic run_eval(input string name, input int head, input int sel, input int dc,
                          input int expv, input int extra);
    int cyc;
    int k;
    int bad_addr;
    int bad_busy;
    bit seen;
    int got_exp;
    exp_q.push_back((expv >= 0) ? expv : model(head, sel, dc));
    head_addr = 8'(head);
    coef_sel  = 2'(sel);
    dc_remove = dc[0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cyc      = 1;
    k        = 0;
    bad_addr = 0;
    bad_busy = 0;
    seen     = 1'b0;
    while (!seen && cyc < 400) begin
      if (busy !== 1'b1) bad_busy++;
      if (xant_ce === 1'b1) begin
        if (xant_addr !== 8'(ring(head, k)) || coef_addr !== {2'(sel), 8'(k)} ||
            coef_ce !== 1'b1) bad_addr++;
        k++;
      end
      // Inputs wander while busy; they must not matter
      if (cyc == 5) begin
        head_addr = 8'($urandom);
        coef_sel  = 2'($urandom);
        dc_remove = 1'($urandom);
      end
      start = (extra != 0 && (cyc == 10 || cyc == 100)) ? 1'b1 : 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    check({name, "_done_cycle"}, 64'(cyc), 64'(M + 4));
    check({name, "_taps"}, 64'(k), 64'(M));
    check({name, "_addr_seq"}, 64'(bad_addr), 64'd0);
    check({name, "_busy"}, 64'(bad_busy), 64'd0);
    if (exp_q.size() == 0) got_exp = -1;
    else got_exp = exp_q.pop_front();
    check({name, "_result"}, 64'(result), 64'(got_exp));
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{"impulse", 1, 0, 5, 1234, 0, 32'h0, 0, 32'h40000000, 5, 0, 0, 1234, 0};
    vecs[1] = '{"wrap", 1, 0, 210, 'h0ABC, 0, 32'h0, 3, 32'h40000000, 2, 0, 0, 'h0ABC, 0};
    vecs[2] = '{"dc_pos", 0, 'h8064, -1, 0, 0, 32'h0, 0, 32'h40000000, 7, 0, 1, 'h8064, 0};
    vecs[3] = '{"dc_neg", 0, 'h8064, -1, 0, 0, 32'h0, 0, 32'hC0000000, 7, 1, 1, 'h7F9C, 0};
    vecs[4] = '{"sat_hi", 0, 'hFFFF, -1, 0, 0, 32'h40000000, -1, 32'h0, 40, 0, 0, 'hFFFF, 0};
    vecs[5] = '{"sat_lo", 0, 'hFFFF, -1, 0, 0, 32'hC0000000, -1, 32'h0, 40, 2, 0, 0, 0};
    vecs[6] = '{"head_oob", 1, 0, 0, 777, 0, 32'h0, 0, 32'h40000000, 250, 0, 0, 777, 0};
    vecs[7] = '{"rand_hpf_dc", 1, 0, -1, 0, 1, 32'h0, -1, 32'h0, 100, 1, 1, -1, 0};
    vecs[8] = '{"busy_bpf", 1, 0, -1, 0, 1, 32'h0, -1, 32'h0, 210, 2, 0, -1, 1};

    rst       = 1'b1;
    start     = 1'b0;
    head_addr = '0;
    coef_sel  = '0;
    dc_remove = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {60'd0, busy, done, xant_ce, coef_ce}, 64'd0);
    check("reset_data", {30'd0, xant_addr, coef_addr, result}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back evaluations: each start lands the cycle after the previous OUT
    foreach (vecs[i]) begin
      setup(vecs[i]);
      run_eval(vecs[i].name, vecs[i].head, vecs[i].sel, vecs[i].dc, vecs[i].exp,
               vecs[i].extra);
      if (vecs[i].extra != 0) begin
        int extra_done;
        extra_done = 0;
        repeat (230) begin
          @(posedge clk);
          #1;
          if (done === 1'b1) extra_done++;
        end
        check("busy_no_queued_done", 64'(extra_done), 64'd0);
      end
    end

    // Reset in the middle of RUN aborts without a done
    setup(vecs[0]);
    head_addr = 8'd5;
    coef_sel  = 2'd0;
    dc_remove = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("pre_reset_active", {62'd0, busy, xant_ce}, 64'd3);
    rst = 1'b1;
    #1;
    check("midrun_reset_ctrl", {60'd0, busy, done, xant_ce, coef_ce}, 64'd0);
    check("midrun_reset_result", 64'(result), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int stray;
      stray = 0;
      repeat (300) begin
        @(posedge clk);
        #1;
        if (done === 1'b1 || busy === 1'b1) stray++;
      end
      check("post_reset_quiet", 64'(stray), 64'd0);
    end
    setup(vecs[1]);
    run_eval("after_reset", vecs[1].head, vecs[1].sel, vecs[1].dc, vecs[1].exp, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
